// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the multiply/divide sequencer.
package md_pkg;
  typedef enum logic [2:0] {MULT, MULTU, DIV, DIVU, MTHI, MTLO} md_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIVS, FIX} md_state_e;
  typedef struct packed {
    logic stall;
    logic busy;
  } md_haz_pkt_t;
  localparam logic [63:0] MD_DIV0_LO = '1;
endpackage

// File: rtl/md_step.sv
// md_step: one radix-2 iteration, shift-add multiply or restoring-divide trial subtract.
module md_step #(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] p,
  input  logic [XLEN-1:0]   m,
  output logic [2*XLEN-1:0] p_nxt
);
  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;
  assign sum   = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
  // remainder is widened by one bit so 2*rem+1 cannot overflow before the compare
  assign diff  = {1'b0, p[2*XLEN-1:XLEN-1]} - {2'b0, m};
  assign p_nxt = div ? {diff[XLEN+1] ? p[2*XLEN-2:XLEN-1] : diff[XLEN-1:0], p[XLEN-2:0], ~diff[XLEN+1]}
                     : {sum, p[XLEN-1:1]};
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: iterative MULT/DIV sequencer owning HI/LO; MD_EARLY_OUT_EN ends multiplies once the multiplier is exhausted.
module md_ctrl
  import md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_vld,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  input  logic            rd_vld,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam logic [CNT_W-1:0] ONE = 1;
  md_state_e state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] p, p_step, p_nxt;
  logic [XLEN-1:0]   m, abs_a, abs_b;
  logic is_div, neg_q, neg_r, sgn, mul_op, div_op, b_zero, acc, last;
  assign sgn    = req_op == MULT || req_op == DIV;
  assign mul_op = req_op == MULT || req_op == MULTU;
  assign div_op = req_op == DIV || req_op == DIVU;
  assign b_zero = req_b == '0;
  assign abs_a  = sgn && req_a[XLEN-1] ? -req_a : req_a;
  assign abs_b  = sgn && req_b[XLEN-1] ? -req_b : req_b;
  assign acc    = state == IDLE && req_vld && !flush;
  assign busy   = state != IDLE;
  assign done   = state == FIX;
  assign stall  = busy && (rd_vld || req_vld);
  md_step #(.XLEN(XLEN)) u_step (.div(is_div), .p(p), .m(m), .p_nxt(p_step));
`ifdef MD_EARLY_OUT_EN
  logic [XLEN-1:0] rem_mask;
  assign rem_mask = ~({XLEN{1'b1}} << (cnt - ONE));
  assign last     = cnt == ONE || (!is_div && (p_step[XLEN-1:0] & rem_mask) == '0);
  assign p_nxt    = !is_div && last ? p_step >> (cnt - ONE) : p_step;
`else
  assign last  = cnt == ONE;
  assign p_nxt = p_step;
`endif
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = !acc ? IDLE : mul_op ? MUL : div_op ? DIVS : IDLE;
    else if (state == FIX) state_nxt = IDLE;
    else if (last) state_nxt = FIX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      if (acc && req_op == MTHI) hi <= req_a;
      if (acc && req_op == MTLO) lo <= req_a;
      if (acc && (mul_op || div_op)) begin
        cnt    <= CNT_W'(XLEN);
        is_div <= div_op;
        // divide by zero keeps the raw dividend so it lands in HI untouched
        p      <= {{XLEN{1'b0}}, div_op ? (b_zero ? req_a : abs_a) : abs_b};
        m      <= div_op ? abs_b : abs_a;
        neg_q  <= sgn && !(div_op && b_zero) && (req_a[XLEN-1] ^ req_b[XLEN-1]);
        neg_r  <= sgn && div_op && !b_zero && req_a[XLEN-1];
      end
      if (state == MUL || state == DIVS) begin
        p   <= p_nxt;
        cnt <= cnt - ONE;
      end
      if (state == FIX && is_div) begin
        lo <= m == '0 ? MD_DIV0_LO[XLEN-1:0] : neg_q ? -p[XLEN-1:0] : p[XLEN-1:0];
        hi <= neg_r ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
      end
      if (state == FIX && !is_div) {hi, lo} <= neg_q ? -p : p;
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed scoreboard bench for md_ctrl.
module tb_md_ctrl;
  import md_pkg::*;
  localparam int XLEN = 32;
  logic clk = 1'b0, rst_n = 1'b0, req_vld = 1'b0, flush = 1'b0, rd_vld = 1'b0;
  logic [2:0] req_op = '0;
  logic [XLEN-1:0] req_a = '0, req_b = '0;
  logic stall, busy, done;
  logic [XLEN-1:0] hi, lo;
  typedef struct {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    int nb;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  logic [XLEN-1:0] m_hi = '0, m_lo = '0;
  always #5 clk = ~clk;
  md_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .flush(flush), .rd_vld(rd_vld), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int mul_busy(input logic [XLEN-1:0] b);
`ifdef MD_EARLY_OUT_EN
    int n = 1;
    for (int i = 0; i < XLEN; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    return XLEN + 1;
`endif
  endfunction
  task automatic issue(input md_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] eh, input logic [XLEN-1:0] el, input int nb);
    @(negedge clk);
    req_vld = 1'b1; req_op = op; req_a = a; req_b = b;
    sb.push_back('{hi: eh, lo: el, nb: nb});
    @(negedge clk);
    req_vld = 1'b0;
  endtask
  task automatic drain(input string tag);
    exp_t e;
    int n = 0, nd = 0;
    while (busy && n < 200) begin
      if (done) nd++;
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({tag, ":busy"}, n, e.nb);
    check({tag, ":done"}, nd, e.nb > 0 ? 1 : 0);
    check({tag, ":hi"}, hi, e.hi);
    check({tag, ":lo"}, lo, e.lo);
    m_hi = e.hi; m_lo = e.lo;
  endtask
  task automatic run(input string tag, input md_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] eh, input logic [XLEN-1:0] el, input int nb);
    issue(op, a, b, eh, el, nb);
    drain(tag);
  endtask
  initial begin
    exp_t e;
    int n, ns;
    logic [XLEN-1:0] a, b;
    logic [2*XLEN-1:0] pr;
    repeat (2) @(negedge clk);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:stall", stall, 0);
    check("rst:hi", hi, 0);
    check("rst:lo", lo, 0);
    rst_n = 1'b1;
    run("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, mul_busy(32'hFFFFFFFF));
    run("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, mul_busy(32'd7));
    run("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("divu_zero", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33);
    run("div_zero_s", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33);
    run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
    run("div_negb", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
    run("multu_small", MULTU, 32'h10, 32'h3, 32'd0, 32'h30, mul_busy(32'h3));
    run("mult_zero", MULT, 32'd12345, 32'd0, 32'd0, 32'd0, mul_busy(32'd0));
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      pr = 64'(a) * 64'(b);
      run("multu_rnd", MULTU, a, b, pr[2*XLEN-1:XLEN], pr[XLEN-1:0], mul_busy(b));
      b = $urandom_range(1, 32'h0001FFFF);
      run("divu_rnd", DIVU, a, b, a % b, a / b, 33);
    end
    run("mthi", MTHI, 32'hCAFEBABE, 32'd0, 32'hCAFEBABE, m_lo, 0);
    @(negedge clk);
    req_vld = 1'b1; flush = 1'b1; req_op = MTLO; req_a = 32'h1234;
    @(negedge clk);
    check("flush_mt:lo", lo, m_lo);
    check("flush_mt:busy", busy, 0);
    req_op = MULT; req_b = 32'd9;
    @(negedge clk);
    check("flush_mul:busy", busy, 0);
    req_vld = 1'b0; flush = 1'b0;
    issue(MULT, 32'd6, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFE2, mul_busy(32'd5));
    rd_vld = 1'b1;
    n = 0; ns = 0;
    while (busy && n < 200) begin
      if (stall) ns++;
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check("rd_stall:cycles", ns, e.nb);
    check("rd_stall:drop", stall, 0);
    check("rd_stall:hi", hi, e.hi);
    check("rd_stall:lo", lo, e.lo);
    rd_vld = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    req_vld = 1'b1; req_op = MTLO; req_a = 32'hABCD;
    n = 0; ns = 0;
    while (busy && n < 200) begin
      if (stall) ns++;
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check("busy_req:stall", ns, e.nb);
    check("busy_req:lo_div", lo, e.lo);
    check("busy_req:hi_div", hi, e.hi);
    @(negedge clk);
    req_vld = 1'b0;
    check("busy_req:lo_mt", lo, 32'hABCD);
    check("busy_req:idle", busy, 0);
    @(negedge clk);
    req_vld = 1'b1; req_op = DIVU; req_a = 32'd1000; req_b = 32'd3;
    @(negedge clk);
    req_vld = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid:busy_pre", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid:busy", busy, 0);
    check("rst_mid:done", done, 0);
    check("rst_mid:hi", hi, 0);
    check("rst_mid:lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid:hi_late", hi, 0);
    check("rst_mid:lo_late", lo, 0);
    check("rst_mid:idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
